seq_detect_param: RTL

- Parametrised Moore serial-pattern detector: shifts one bit of x in per enabled clock and flags when the most recent len bits equal a run-time programmable pattern.
- Supports pattern lengths 1..N, overlapping and non-overlapping modes, a saturating match counter and a synchronous clear.
- Sits after a serial line or bit-stream source; match and match_count feed control/status logic.

---
 rtl/seq_detect_param_if.sv | 33 +++
 rtl/seq_detect_param.sv | 104 ++++++++++
 2 files changed

// File: rtl/seq_detect_param_if.sv
// Bundles the configuration, serial input and status signals of seq_detect_param.
//   en, x, clear          : bit strobe, serial bit, synchronous clear (master -> slave)
//   pattern, len, overlap : run-time detector configuration (master -> slave)
//   match, match_count,
//   filled                : detector status (slave -> master)
interface seq_detect_param_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned LW = $clog2(N + 1);

    logic             en;
    logic             x;
    logic             clear;
    logic [N-1:0]     pattern;
    logic [LW-1:0]    len;
    logic             overlap;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             filled;

    // Bit source / configuration owner.
    modport master (
        output en, x, clear, pattern, len, overlap,
        input  match, match_count, filled
    );

    // Detector side.
    modport slave (
        input  en, x, clear, pattern, len, overlap,
        output match, match_count, filled
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector. One bit of x is shifted in per
// enabled clock; match flags when the newest L bits equal pattern[L-1:0].
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport of seq_detect_param_if
//              inputs  en, x, clear, pattern, len, overlap
//              outputs match (decoded from state + config), match_count
//              (registered, saturating), filled (fill >= effective length)
module seq_detect_param #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    seq_detect_param_if.slave   bus
);
    localparam int unsigned LW = $clog2(N + 1);

    logic [N-1:0]     hist_q, hist_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic [LW-1:0]    eff_len_c;
    logic [N-1:0]     mask_c;
    logic             match_c;
    logic             filled_c;
    logic             filled_next_c;
    logic             match_next_c;

    // Effective pattern length: 0 behaves as 1, anything above N clamps to N.
    always_comb begin
        eff_len_c = bus.len;
        if (bus.len == LW'(0)) begin
            eff_len_c = LW'(1);
        end else if (bus.len > LW'(N)) begin
            eff_len_c = LW'(N);
        end
    end

    // Compare mask covering the low eff_len_c bits of history and pattern.
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask_c[i] = (32'(i) < 32'(eff_len_c));
        end
    end

    // Moore outputs: registered state qualified by static configuration only.
    always_comb begin
        filled_c = (fill_q >= eff_len_c);
        match_c  = filled_c && ((hist_q & mask_c) == (bus.pattern & mask_c));
    end

    // Next-state: clear beats en; en shifts x in and advances/restarts fill.
    always_comb begin
        hist_d        = hist_q;
        fill_d        = fill_q;
        cnt_d         = cnt_q;
        filled_next_c = 1'b0;
        match_next_c  = 1'b0;

        if (bus.clear) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (bus.en) begin
            hist_d = {hist_q[N-2:0], bus.x};
            if (!bus.overlap && match_c) begin
                // Non-overlapping: the matched bits may not be reused.
                fill_d = LW'(1);
            end else if (fill_q >= LW'(N)) begin
                fill_d = LW'(N);
            end else begin
                fill_d = fill_q + LW'(1);
            end

            // Count every enabled edge that lands in a matching state.
            filled_next_c = (fill_d >= eff_len_c);
            match_next_c  = filled_next_c
                          && ((hist_d & mask_c) == (bus.pattern & mask_c));
            if (match_next_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.match       = match_c;
    assign bus.filled      = filled_c;
    assign bus.match_count = cnt_q;

endmodule
